// File: rtl/vram_pkg.sv
// Shared VRAM bus widths, burst geometry and arbiter state encoding.
package vram_pkg;

    localparam int unsigned VRAM_ADDR_W = 20;
    localparam int unsigned VRAM_DATA_W = 24;
    localparam int unsigned LINE_WORDS  = 512;
    localparam int unsigned COLUMN_W    = 9;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        DISP_READ,
        DISP_DRAIN
    } vram_state_t;

    function automatic logic is_display_state(input vram_state_t s);
        return (s == DISP_READ) || (s == DISP_DRAIN);
    endfunction

endpackage

// File: rtl/vram_return_pipe.sv
// Delays the {valid, column} tag of each issued read to line up with returned data,
// then registers tag and data together for the video line buffer.
module vram_return_pipe
    import vram_pkg::*;
#(
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic                   i_clk,
    input  logic                   i_reset_n,
    input  logic                   i_valid,
    input  logic [COLUMN_W-1:0]    i_column,
    input  logic [VRAM_DATA_W-1:0] i_rdata,
    output logic                   o_valid,
    output logic [COLUMN_W-1:0]    o_column,
    output logic [VRAM_DATA_W-1:0] o_data
);

    localparam int RL = int'(READ_LATENCY);

    logic [RL-1:0]               r_valid_sr;
    logic [RL-1:0][COLUMN_W-1:0] r_column_sr;
    logic                        r_valid;
    logic [COLUMN_W-1:0]         r_column;
    logic [VRAM_DATA_W-1:0]      r_data;

    // Async clear drops in-flight tags so an aborted burst emits nothing more.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_valid_sr  <= '0;
            r_column_sr <= '0;
            r_valid     <= 1'b0;
            r_column    <= '0;
            r_data      <= '0;
        end else begin
            r_valid_sr[0]  <= i_valid;
            r_column_sr[0] <= i_column;
            for (int i = 1; i < RL; i++) begin
                r_valid_sr[i]  <= r_valid_sr[i-1];
                r_column_sr[i] <= r_column_sr[i-1];
            end
            r_valid  <= r_valid_sr[RL-1];
            r_column <= r_valid_sr[RL-1] ? r_column_sr[RL-1] : '0;
            r_data   <= r_valid_sr[RL-1] ? i_rdata : '0;
        end
    end

    assign o_valid  = r_valid;
    assign o_column = r_column;
    assign o_data   = r_data;

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM bus arbiter: display line bursts have absolute priority,
// renderer single-word writes fill idle bus time via a req/ack handshake.
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic                   i_master_clk,
    input  logic                   i_reset_n,
    input  logic [VRAM_ADDR_W-1:0] i_vram_display_address,
    input  logic                   i_vram_display_start,
    output logic [COLUMN_W-1:0]    o_vram_display_column,
    output logic [VRAM_DATA_W-1:0] o_vram_display_data,
    output logic                   o_vram_display_data_valid,
    output logic                   o_display_busy,
    output logic                   o_display_overrun,
    input  logic                   i_render_write_req,
    input  logic [VRAM_ADDR_W-1:0] i_render_write_address,
    input  logic [VRAM_DATA_W-1:0] i_render_write_data,
    output logic                   o_render_write_ack,
    output logic [VRAM_ADDR_W-1:0] o_mem_address,
    output logic                   o_mem_read,
    output logic                   o_mem_write,
    output logic [VRAM_DATA_W-1:0] o_mem_wdata,
    input  logic [VRAM_DATA_W-1:0] i_mem_rdata
);

    localparam int unsigned DRAIN_W = 3;

    vram_state_t            r_state, w_state_next;
    logic                   r_pending, w_pending_next;
    logic [VRAM_ADDR_W-1:0] r_base, w_base;
    logic [COLUMN_W-1:0]    r_col, w_col_next, w_col_inc;
    logic [DRAIN_W-1:0]     r_drain, w_drain_next;
    logic                   r_overrun, r_busy;
    logic                   r_mem_read, w_mem_read;
    logic                   r_mem_write, w_mem_write;
    logic                   r_ack, w_ack;
    logic [VRAM_ADDR_W-1:0] r_mem_address, w_mem_address;
    logic [VRAM_DATA_W-1:0] r_mem_wdata, w_mem_wdata;
    logic                   w_start_take, w_overrun_hit, w_disp_go;

    assign w_start_take  = i_vram_display_start && !r_pending &&
                           ((r_state == IDLE) || (r_state == WRITE));
    assign w_overrun_hit = i_vram_display_start && (r_pending || is_display_state(r_state));
    assign w_disp_go     = r_pending || w_start_take;
    // Column 0 must issue on the start edge, before the base register has loaded.
    assign w_base        = w_start_take ? i_vram_display_address : r_base;
    assign w_col_inc     = r_col + COLUMN_W'(1);

    always_comb begin
        w_state_next   = r_state;
        w_pending_next = r_pending;
        w_col_next     = r_col;
        w_drain_next   = r_drain;
        w_mem_read     = 1'b0;
        w_mem_write    = 1'b0;
        w_mem_address  = '0;
        w_mem_wdata    = '0;
        w_ack          = 1'b0;

        if (w_start_take) begin
            w_pending_next = 1'b1;
        end

        unique case (r_state)
            IDLE, WRITE: begin
                if (w_disp_go) begin
                    w_state_next   = DISP_READ;
                    w_pending_next = 1'b0;
                    w_col_next     = '0;
                    w_mem_read     = 1'b1;
                    w_mem_address  = w_base;
                end else if ((r_state == IDLE) && i_render_write_req) begin
                    w_state_next  = WRITE;
                    w_mem_write   = 1'b1;
                    w_mem_address = i_render_write_address;
                    w_mem_wdata   = i_render_write_data;
                    w_ack         = 1'b1;
                end else begin
                    w_state_next = IDLE;
                end
            end
            DISP_READ: begin
                if (r_col == COLUMN_W'(LINE_WORDS - 1)) begin
                    w_state_next = DISP_DRAIN;
                    w_drain_next = '0;
                end else begin
                    w_col_next    = w_col_inc;
                    w_mem_read    = 1'b1;
                    w_mem_address = r_base + VRAM_ADDR_W'(w_col_inc);
                end
            end
            DISP_DRAIN: begin
                if (r_drain == DRAIN_W'(READ_LATENCY - 1)) begin
                    w_state_next = IDLE;
                end else begin
                    w_drain_next = r_drain + DRAIN_W'(1);
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_master_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state       <= IDLE;
            r_pending     <= 1'b0;
            r_base        <= '0;
            r_col         <= '0;
            r_drain       <= '0;
            r_overrun     <= 1'b0;
            r_busy        <= 1'b0;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_ack         <= 1'b0;
            r_mem_address <= '0;
            r_mem_wdata   <= '0;
        end else begin
            r_state       <= w_state_next;
            r_pending     <= w_pending_next;
            r_base        <= w_base;
            r_col         <= w_col_next;
            r_drain       <= w_drain_next;
            r_overrun     <= r_overrun | w_overrun_hit;
            r_busy        <= is_display_state(w_state_next);
            r_mem_read    <= w_mem_read;
            r_mem_write   <= w_mem_write;
            r_ack         <= w_ack;
            r_mem_address <= w_mem_address;
            r_mem_wdata   <= w_mem_wdata;
        end
    end

    vram_return_pipe #(
        .READ_LATENCY (READ_LATENCY)
    ) u_return_pipe (
        .i_clk     (i_master_clk),
        .i_reset_n (i_reset_n),
        .i_valid   (r_mem_read),
        .i_column  (r_col),
        .i_rdata   (i_mem_rdata),
        .o_valid   (o_vram_display_data_valid),
        .o_column  (o_vram_display_column),
        .o_data    (o_vram_display_data)
    );

    assign o_display_busy     = r_busy;
    assign o_display_overrun  = r_overrun;
    assign o_render_write_ack = r_ack;
    assign o_mem_address      = r_mem_address;
    assign o_mem_read         = r_mem_read;
    assign o_mem_write        = r_mem_write;
    assign o_mem_wdata        = r_mem_wdata;

endmodule
